pool_sequencer: RTL

//  Sequences the pooler over CH stacked MxM feature maps held in a 1-cycle-latency feature RAM.

---
 rtl/pool_sequencer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/pool_sequencer.sv
// pool_sequencer: walks CH stacked MxM feature maps out of a 1-cycle-latency feature RAM,
// streams each map in raster order into a PxP pooler, clears the pooler between maps and
// writes every pooled result to a packed channel-major output buffer address.
// Optional feature: define POOL_SEQ_PERF_EN to add the cyc_cnt busy-cycle counter port.
module pool_sequencer #(
    parameter int unsigned M         = 12,
    parameter int unsigned P         = 3,
    parameter int unsigned N         = 16,
    parameter int unsigned CH        = 4,
    parameter int unsigned AW        = 10,
    parameter int unsigned OW        = 6,
    parameter int unsigned DRAIN_MAX = 64
) (
    input  logic          clk,
    input  logic          master_rst,
    input  logic          start,
    input  logic          hold,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [N-1:0]  rd_data,
    output logic          pool_rst_n,
    output logic          pool_ce,
    output logic [N-1:0]  pool_din,
    input  logic          pool_valid,
    input  logic          pool_end,
    input  logic [N-1:0]  pool_dout,
    output logic          wr_en,
    output logic [OW-1:0] wr_addr,
    output logic [N-1:0]  wr_data
`ifdef POOL_SEQ_PERF_EN
    ,
    output logic [31:0]   cyc_cnt
`endif
);

    localparam int unsigned MM  = M * M;
    localparam int unsigned R   = (M / P) * (M / P);
    localparam int unsigned CW  = $clog2(CH + 1);
    localparam int unsigned TW  = $clog2(DRAIN_MAX + 1);
    // One extra bit so a per-map result count of exactly 2^OW is still representable.
    localparam int unsigned OCW = OW + 1;

    localparam logic [AW-1:0]  MM_A     = AW'(MM);
    localparam logic [AW-1:0]  LAST_PIX = AW'(MM - 1);
    localparam logic [OW-1:0]  R_O      = OW'(R);
    localparam logic [OCW-1:0] R_C      = OCW'(R);
    localparam logic [CW-1:0]  CH_C     = CW'(CH);
    localparam logic [TW-1:0]  DRAIN_T  = TW'(DRAIN_MAX);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStream,
        StDrain,
        StNext,
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic           clr_q, clr_d;
    logic [CW-1:0]  ch_q, ch_d;
    logic [AW-1:0]  pix_q, pix_d;
    logic [OCW-1:0] ocnt_q, ocnt_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           err_q, err_d;
    logic           rd_en_q;

    logic [OCW-1:0] ocnt_inc;
    logic [CW-1:0]  ch_inc;
    logic [TW-1:0]  timer_inc;

    // State and counter registers; async reset aborts any job immediately.
    always_ff @(posedge clk or negedge master_rst) begin
        if (!master_rst) begin
            state_q <= StIdle;
            clr_q   <= 1'b0;
            ch_q    <= '0;
            pix_q   <= '0;
            ocnt_q  <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
            rd_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            ch_q    <= ch_d;
            pix_q   <= pix_d;
            ocnt_q  <= ocnt_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            rd_en_q <= rd_en;
        end
    end

    // Sequencing FSM: next state, counters and the RAM read strobe.
    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        ch_d      = ch_q;
        pix_d     = pix_q;
        timer_d   = timer_q;
        err_d     = err_q;
        rd_en     = 1'b0;
        ocnt_inc  = ocnt_q + OCW'(wr_en);
        ocnt_d    = ocnt_inc;
        ch_inc    = ch_q + CW'(1);
        timer_inc = timer_q + TW'(1);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StClear;
                    clr_d   = 1'b0;
                    ch_d    = '0;
                    pix_d   = '0;
                    ocnt_d  = '0;
                    timer_d = '0;
                    err_d   = 1'b0;
                end
            end
            StClear: begin
                // Two cycles with the pooler held in reset.
                clr_d = 1'b1;
                if (clr_q) begin
                    clr_d   = 1'b0;
                    state_d = StStream;
                end
            end
            StStream: begin
                rd_en   = !hold;
                timer_d = '0;
                if (!hold) begin
                    pix_d = pix_q + AW'(1);
                    if (pix_q == LAST_PIX) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pool_end) begin
                    state_d = StNext;
                end else begin
                    timer_d = timer_inc;
                    if (timer_inc == DRAIN_T) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StNext: begin
                // Count includes a write landing in this very cycle.
                if (ocnt_inc != R_C) begin
                    err_d = 1'b1;
                end
                ocnt_d = '0;
                pix_d  = '0;
                ch_d   = ch_inc;
                clr_d  = 1'b0;
                if (ch_inc == CH_C) begin
                    state_d = StDone;
                end else begin
                    state_d = StClear;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Status, pooler interface and writeback outputs.
    always_comb begin
        busy       = (state_q == StClear) || (state_q == StStream) ||
                     (state_q == StDrain) || (state_q == StNext);
        done       = (state_q == StDone);
        err        = err_q;
        pool_rst_n = !((state_q == StIdle) || (state_q == StClear));
        rd_addr    = '0;
        if (state_q == StStream) begin
            rd_addr = AW'(ch_q) * MM_A + pix_q;
        end
        pool_ce  = rd_en_q;
        pool_din = rd_en_q ? rd_data : '0;
        // Reset gates the write strobe so the buffer sees nothing while the block is held.
        wr_en    = pool_valid & master_rst;
        wr_addr  = wr_en ? (OW'(ch_q) * R_O + OW'(ocnt_q)) : '0;
        wr_data  = wr_en ? pool_dout : '0;
    end

`ifdef POOL_SEQ_PERF_EN
    logic [31:0] cyc_q, cyc_d;

    // Busy-cycle counter: clears on accepted start, holds once the job ends.
    always_comb begin
        cyc_d = cyc_q;
        if ((state_q == StIdle) && start) begin
            cyc_d = '0;
        end else if (busy) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    // Busy-cycle counter register.
    always_ff @(posedge clk or negedge master_rst) begin
        if (!master_rst) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign cyc_cnt = cyc_q;
`endif

endmodule
